// File: rtl/stats_pkg.sv
// Shared constants and FSM encoding for the statistics finalizer.
package stats_pkg;

  localparam int ACC_W     = 64;
  localparam int CNT_W     = 32;
  localparam int MEAN_W    = 16;
  localparam int VAR_W     = 32;
  localparam int STATS_LAT = 2 * ACC_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    DIV_MEAN,
    DIV_MSQ,
    CALC,
    FIN
  } state_t;

endpackage

// File: rtl/stats_finalize_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
module seq_divider #(
  parameter int DIVIDEND_W = 64,
  parameter int DIVISOR_W  = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  done
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  logic                  busy;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] q_r, src_q, q_nxt;
  logic [DIVISOR_W-1:0]  rem_r, div_r, src_rem, src_div, rem_nxt;
  logic [DIVISOR_W:0]    trial, diff;
  logic                  accept, ge;

  assign accept = start && !busy;

  // The first step is folded into the launch edge so a full divide
  // takes exactly DIVIDEND_W edges including the one that accepts start.
  always_comb begin
    src_q   = accept ? dividend : q_r;
    src_rem = accept ? '0 : rem_r;
    src_div = accept ? divisor : div_r;
    trial   = {src_rem, src_q[DIVIDEND_W-1]};
    diff    = trial - {1'b0, src_div};
    ge      = (trial >= {1'b0, src_div});
    rem_nxt = ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    q_nxt   = {src_q[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      q_r   <= '0;
      rem_r <= '0;
      div_r <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        q_r   <= q_nxt;
        rem_r <= rem_nxt;
        div_r <= divisor;
        cnt   <= CW'(1);
        busy  <= 1'b1;
      end else if (busy) begin
        q_r   <= q_nxt;
        rem_r <= rem_nxt;
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(DIVIDEND_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = q_r;
  assign remainder = rem_r;

endmodule

// File: rtl/stats_finalize.sv
// Finalizes mean, mean-square and variance from accumulator totals using
// one shared serial divider.
module stats_finalize #(
  parameter int ACC_W  = stats_pkg::ACC_W,
  parameter int CNT_W  = stats_pkg::CNT_W,
  parameter int MEAN_W = stats_pkg::MEAN_W,
  parameter int VAR_W  = stats_pkg::VAR_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [ACC_W-1:0]  sum_in,
  input  logic [ACC_W-1:0]  sum_square_in,
  input  logic [CNT_W-1:0]  count_in,
  output logic              busy,
  output logic              done,
  output logic [MEAN_W-1:0] mean_out,
  output logic [VAR_W-1:0]  msq_out,
  output logic [VAR_W-1:0]  var_out,
  output logic              err_div0,
  output logic              ovf
);
  import stats_pkg::*;

  state_t state, state_nxt;

  logic [ACC_W-1:0]    sumsq_q, q_mean, q_msq;
  logic [CNT_W-1:0]    count_q;
  logic                div_start, div_done;
  logic [ACC_W-1:0]    div_dividend, div_quotient;
  logic [CNT_W-1:0]    div_divisor;
  logic [MEAN_W-1:0]   mean_sat;
  logic [VAR_W-1:0]    msq_sat, var_calc;
  logic [2*MEAN_W-1:0] sq;
  logic                mean_clip, msq_clip, var_clip;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = (count_in == '0) ? FIN : DIV_MEAN;
      DIV_MEAN: if (div_done) state_nxt = DIV_MSQ;
      DIV_MSQ:  if (div_done) state_nxt = CALC;
      CALC:     state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // The mean divide takes its operands straight from the ports on the
  // accepting edge; the mean-square divide uses the latched copies.
  always_comb begin
    busy         = (state == DIV_MEAN) || (state == DIV_MSQ) || (state == CALC);
    done         = (state == FIN);
    div_start    = ((state == IDLE) && start && (count_in != '0)) ||
                   ((state == DIV_MEAN) && div_done);
    div_dividend = (state == IDLE) ? sum_in : sumsq_q;
    div_divisor  = (state == IDLE) ? count_in : count_q;
  end

  seq_divider #(
    .DIVIDEND_W(ACC_W),
    .DIVISOR_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .nreset   (nreset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .remainder(),
    .done     (div_done)
  );

  always_comb begin
    mean_clip = |q_mean[ACC_W-1:MEAN_W];
    msq_clip  = |q_msq[ACC_W-1:VAR_W];
    mean_sat  = mean_clip ? '1 : q_mean[MEAN_W-1:0];
    msq_sat   = msq_clip ? '1 : q_msq[VAR_W-1:0];
    sq        = {{MEAN_W{1'b0}}, mean_sat} * {{MEAN_W{1'b0}}, mean_sat};
    var_clip  = (msq_sat < sq);
    var_calc  = var_clip ? '0 : (msq_sat - sq);
  end

  // Results land on the edge entering FIN so they are valid alongside done.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sumsq_q  <= '0;
      count_q  <= '0;
      q_mean   <= '0;
      q_msq    <= '0;
      mean_out <= '0;
      msq_out  <= '0;
      var_out  <= '0;
      err_div0 <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        sumsq_q <= sum_square_in;
        count_q <= count_in;
        if (count_in == '0) begin
          mean_out <= '0;
          msq_out  <= '0;
          var_out  <= '0;
          err_div0 <= 1'b1;
          ovf      <= 1'b0;
        end
      end
      if ((state == DIV_MEAN) && div_done) q_mean <= div_quotient;
      if ((state == DIV_MSQ) && div_done)  q_msq  <= div_quotient;
      if (state == CALC) begin
        mean_out <= mean_sat;
        msq_out  <= msq_sat;
        var_out  <= var_calc;
        err_div0 <= 1'b0;
        ovf      <= mean_clip | msq_clip | var_clip;
      end
    end
  end

endmodule

// File: tb/tb_stats_finalize.sv
// Directed bench for stats_finalize: latency, results, saturation, start
// filtering and asynchronous abort.
module tb_stats_finalize;
  import stats_pkg::*;

  logic              clk;
  logic              nreset;
  logic              start;
  logic [ACC_W-1:0]  sum_in;
  logic [ACC_W-1:0]  sum_square_in;
  logic [CNT_W-1:0]  count_in;
  logic              busy;
  logic              done;
  logic [MEAN_W-1:0] mean_out;
  logic [VAR_W-1:0]  msq_out;
  logic [VAR_W-1:0]  var_out;
  logic              err_div0;
  logic              ovf;

  int tests = 0;
  int fails = 0;
  int lat, ndone;
  bit busy_seen;

  stats_finalize dut (
    .clk          (clk),
    .nreset       (nreset),
    .start        (start),
    .sum_in       (sum_in),
    .sum_square_in(sum_square_in),
    .count_in     (count_in),
    .busy         (busy),
    .done         (done),
    .mean_out     (mean_out),
    .msq_out      (msq_out),
    .var_out      (var_out),
    .err_div0     (err_div0),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency k is the index of the clock edge, counted from the accepting
  // edge, at which a synchronous reader first sees done high.
  task automatic applyStimulus(input logic [63:0] s, input logic [63:0] sq,
                               input logic [31:0] n, input int inj_a, input int inj_b,
                               output int lat_o, output int ndone_o, output bit busy_o);
    @(negedge clk);
    sum_in        = s;
    sum_square_in = sq;
    count_in      = n;
    start         = 1'b1;
    lat_o   = 0;
    ndone_o = 0;
    busy_o  = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start         = (k == inj_a) || (k == inj_b);
      sum_in        = {$urandom, $urandom};
      sum_square_in = {$urandom, $urandom};
      count_in      = $urandom;
      if (busy) busy_o = 1'b1;
      if (done) begin
        ndone_o++;
        if (lat_o == 0) lat_o = k;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    nreset        = 1'b0;
    start         = 1'b0;
    sum_in        = '0;
    sum_square_in = '0;
    count_in      = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_mean", mean_out, 0);
    checkOutput("rst_msq", msq_out, 0);
    checkOutput("rst_var", var_out, 0);
    checkOutput("rst_err", err_div0, 0);
    checkOutput("rst_ovf", ovf, 0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(64'd10, 64'd30, 32'd4, 0, 0, lat, ndone, busy_seen);
    checkOutput("basic_lat", lat, STATS_LAT);
    checkOutput("basic_ndone", ndone, 1);
    checkOutput("basic_busy", busy_seen, 1);
    checkOutput("basic_mean", mean_out, 2);
    checkOutput("basic_msq", msq_out, 7);
    checkOutput("basic_var", var_out, 3);
    checkOutput("basic_ovf", ovf, 0);
    checkOutput("basic_err", err_div0, 0);

    applyStimulus(64'd5, 64'd0, 32'd0, 0, 0, lat, ndone, busy_seen);
    checkOutput("div0_lat", lat, 1);
    checkOutput("div0_ndone", ndone, 1);
    checkOutput("div0_busy", busy_seen, 0);
    checkOutput("div0_err", err_div0, 1);
    checkOutput("div0_mean", mean_out, 0);
    checkOutput("div0_msq", msq_out, 0);
    checkOutput("div0_var", var_out, 0);
    checkOutput("div0_ovf", ovf, 0);

    applyStimulus(64'd65535000, 64'd4294836225000, 32'd1000, 0, 0, lat, ndone, busy_seen);
    checkOutput("full_lat", lat, STATS_LAT);
    checkOutput("full_mean", mean_out, 65535);
    checkOutput("full_msq", msq_out, 64'd4294836225);
    checkOutput("full_var", var_out, 0);
    checkOutput("full_ovf", ovf, 0);
    checkOutput("full_err", err_div0, 0);

    applyStimulus(64'h20000, 64'd0, 32'd1, 0, 0, lat, ndone, busy_seen);
    checkOutput("satm_mean", mean_out, 16'hFFFF);
    checkOutput("satm_msq", msq_out, 0);
    checkOutput("satm_var", var_out, 0);
    checkOutput("satm_ovf", ovf, 1);

    applyStimulus(64'd10, 64'd0, 32'd1, 0, 0, lat, ndone, busy_seen);
    checkOutput("clamp_mean", mean_out, 10);
    checkOutput("clamp_var", var_out, 0);
    checkOutput("clamp_ovf", ovf, 1);

    // Divisor with its MSB set; mean-square overflows 32 bits.
    applyStimulus(64'h1_0000_0000, 64'h8000_0000_0000_0000, 32'h8000_0000, 0, 0,
                  lat, ndone, busy_seen);
    checkOutput("msb_mean", mean_out, 2);
    checkOutput("msb_msq", msq_out, 32'hFFFF_FFFF);
    checkOutput("msb_var", var_out, 32'hFFFF_FFFB);
    checkOutput("msb_ovf", ovf, 1);

    applyStimulus(64'd3, 64'd5, 32'd2, 10, 129, lat, ndone, busy_seen);
    checkOutput("inj_lat", lat, STATS_LAT);
    checkOutput("inj_ndone", ndone, 1);
    checkOutput("inj_mean", mean_out, 1);
    checkOutput("inj_msq", msq_out, 2);
    checkOutput("inj_var", var_out, 1);

    // Abort an operation with reset at edge 60.
    @(negedge clk);
    sum_in        = 64'd1000;
    sum_square_in = 64'd200000;
    count_in      = 32'd10;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    nreset = 1'b0;
    #1;
    checkOutput("abort_mean", mean_out, 0);
    checkOutput("abort_msq", msq_out, 0);
    checkOutput("abort_var", var_out, 0);
    checkOutput("abort_busy", busy, 0);
    @(negedge clk);
    nreset = 1'b1;
    ndone  = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checkOutput("abort_nodone", ndone, 0);

    applyStimulus(64'd100, 64'd1100, 32'd10, 0, 0, lat, ndone, busy_seen);
    checkOutput("post_lat", lat, STATS_LAT);
    checkOutput("post_mean", mean_out, 10);
    checkOutput("post_msq", msq_out, 110);
    checkOutput("post_var", var_out, 10);
    checkOutput("post_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stats_finalize.md
Name: stats_finalize

Overview:
- Consumes the 64-bit running sum and sum-of-squares produced by the sample accumulator, plus the sample count N from the acquisition controller.
- On a start pulse, computes mean = floor(sum/N), mean-square = floor(sumsq/N) and variance = mean-square − mean², using one shared bit-serial divider.
- Sits between the accumulator and the host register interface; its results are what software reads after an acquisition window closes.

Parameters:
- ACC_W, 64, width of sum_in and sum_square_in (divider dividend width; sets divide latency).
- CNT_W, 32, width of count_in (divider divisor width).
- MEAN_W, 16, width of mean_out (sample width).
- VAR_W, 32, width of msq_out and var_out.

Ports:
- clk  in  1  clock.
- nreset  in  1  reset nreset, asynchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- sum_in  in  ACC_W  unsigned sum of samples.
- sum_square_in  in  ACC_W  unsigned sum of squared samples.
- count_in  in  CNT_W  unsigned sample count N.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when outputs are valid.
- mean_out  out  MEAN_W  floor(sum/N), saturated.
- msq_out  out  VAR_W  floor(sumsq/N), saturated.
- var_out  out  VAR_W  msq − mean², clamped at 0.
- err_div0  out  1  last request had N = 0.
- ovf  out  1  last request saturated mean_out or msq_out, or clamped var_out.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; internal registers 0.
  - Asserting nreset mid-operation aborts immediately; no done pulse follows.
- FSM states: IDLE, DIV_MEAN, DIV_MSQ, CALC, FIN.
- IDLE:
  - On start=1, latch sum_in, sum_square_in and count_in on that edge. Inputs are don't-care afterwards.
  - If latched N = 0: go to FIN with err_div0=1, ovf=0, and mean_out/msq_out/var_out forced to 0.
  - Otherwise: go to DIV_MEAN, launch the divider, set busy=1.
- DIV_MEAN:
  - Divider runs ACC_W cycles of restoring division, one quotient bit per cycle, MSB first.
  - On divider done, capture the quotient and go to DIV_MSQ, relaunching the divider with sumsq/N.
- DIV_MSQ:
  - Same ACC_W-cycle division.
  - On done, capture the quotient and go to CALC.
- CALC, one cycle:
  - mean_sat = min(q_mean, 2^MEAN_W − 1).
  - msq_sat = min(q_msq, 2^VAR_W − 1).
  - sq = mean_sat², full 2·MEAN_W bits.
  - var = msq_sat − sq if msq_sat ≥ sq, else 0.
  - ovf is set if any saturation or clamp occurred.
- FIN, one cycle:
  - Update outputs, pulse done=1, deassert busy, set err_div0 (0 for a nonzero N).
  - Return to IDLE.
- Latency: done is high exactly 2·ACC_W + 2 cycles after the start-sampling edge (130 at defaults). For N = 0, done is high 1 cycle after that edge.
- Output holding: outputs hold their values until the next FIN or reset. They do not change while busy.
- Start handling: start while busy is ignored (not queued). Start in the FIN cycle is also ignored.
- Arithmetic: all operands are unsigned; remainders are discarded (truncation, not rounding).
- Divider partial remainder is CNT_W+1 bits wide, so a divisor with MSB set divides correctly.

Decomposition:
- Shared package stats_pkg holds:
  - the FSM state encoding;
  - width constants ACC_W=64, CNT_W=32, MEAN_W=16, VAR_W=32;
  - the latency constant STATS_LAT = 2·ACC_W + 2.
- One sub-module, seq_divider:
  - parameters DIVIDEND_W, DIVISOR_W;
  - ports clk, nreset, start, dividend, divisor, quotient, remainder, done;
  - a start while it is busy is ignored.
- The square (16×16) and the subtract live in stats_finalize.

Test Plan:
- Samples 1,2,3,4 (sum=10, sumsq=30, N=4), start → done at +130; mean_out=2, msq_out=7, var_out=3, ovf=0, err_div0=0.
- N=0, sum=5, start → done at +1; err_div0=1, all results 0, busy never high.
- 1000 samples of 65535 (sum=65,535,000, sumsq=4,294,836,225,000) → mean_out=65535, msq_out=4,294,836,225, var_out=0, ovf=0.
- Saturation and clamp:
  - sum=0x20000, sumsq=0, N=1 → mean_out=0xFFFF, msq_out=0, var_out=0, ovf=1.
  - sum=10, sumsq=0, N=1 → var_out=0, ovf=1.
- Start pulses at +10 and +129 during an operation (sum=3, sumsq=5, N=2) → single done at +130; mean 1, msq 2, var 1; no second done.
- nreset low at +60 of an operation → outputs 0, busy 0, no done; a fresh start after release completes in 130 cycles with correct values.
